// File: rtl/commit_scoreboard.sv
// commit_scoreboard: shadow-ISA golden checker that replays ROB commits and compares against the CPU register file.
// Optional fetched-PC history check is built when COMMIT_SCOREBOARD_PC_CHECK_EN is defined.

package commit_scoreboard_pkg;
  localparam int CS_XLEN  = 32;
  localparam int CS_TAG_W = 3;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  typedef struct packed {
    logic [CS_XLEN-1:0] pc;
    logic [CS_XLEN-1:0] branch_pc;
    logic               taken;
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [CS_XLEN-1:0] i_imm;
    logic [CS_XLEN-1:0] u_imm;
    logic [CS_XLEN-1:0] j_imm;
  } pc_info_t;

  typedef struct packed {
    logic               rdy;
    logic [CS_XLEN-1:0] data;
    pc_info_t           pc_info;
  } sal2_t;

  typedef struct packed {
    logic [CS_TAG_W-1:0] front_tag;
  } flush_t;

  typedef struct packed {
    logic [CS_XLEN-1:0] data;
  } reg_entry_t;
endpackage

module commit_scoreboard
  import commit_scoreboard_pkg::*;
#(
  parameter int              XLEN     = CS_XLEN,
  parameter int              ROB_SIZE = 8,
  parameter int              NUM_REGS = 32,
  parameter int              PC_HIST  = 8,
  parameter int              CNT_W    = 16,
  parameter logic [XLEN-1:0] RESET_PC = 32'h60
) (
  input  logic             clk,
  input  logic             rst,
  // commit is a valid-only strobe: every cycle it is high the ready entries are consumed; there is no back-pressure.
  input  logic             commit,
  input  sal2_t            rdest [ROB_SIZE],
  input  flush_t           flush,
  input  reg_entry_t       cpu_registers [NUM_REGS],
  input  logic             halt,
  input  logic [XLEN-1:0]  pc,
  input  logic             pc_load,
  output logic [CNT_W-1:0] num_err,
  output logic [CNT_W-1:0] num_commit,
  output logic             mismatch,
  output logic             pc_mismatch,
  output logic             first_err_valid,
  output logic [4:0]       first_err_reg,
  output logic [XLEN-1:0]  first_err_exp,
  output logic [XLEN-1:0]  first_err_act,
  output logic             done,
  output logic [1:0]       dbg_state
);
  localparam int TAG_W = $clog2(ROB_SIZE);
  localparam int RC_W  = $clog2(ROB_SIZE + 1);
  localparam int SUM_W = CNT_W + RC_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_RUN = 2'd0, S_CHECK = 2'd1, S_HALTED = 2'd2} state_t;

  state_t          state;
  logic [XLEN-1:0] shadow_q [NUM_REGS];
  logic [XLEN-1:0] exp_pc_q;

  logic [XLEN-1:0] sh_n [NUM_REGS];
  logic [XLEN-1:0] epc_n, rs1_v, rs2_v, res;
  logic [TAG_W-1:0] idx;
  logic [RC_W-1:0] rdy_cnt;
  sal2_t           ent;
  logic            wr, do_ingest, any_mis, pc_hit;
  logic [4:0]      mis_idx;
  logic [SUM_W-1:0] commit_sum;
  logic [CNT_W-1:0] commit_sat;
  logic            unused_f7;

  function automatic logic [XLEN-1:0] alu(input logic [2:0] f3, input logic alt, input logic is_reg,
                                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (f3)
      3'd0:    alu = (is_reg && alt) ? a - b : a + b;
      3'd1:    alu = a << sh;
      3'd2:    alu = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      3'd3:    alu = {{(XLEN-1){1'b0}}, a < b};
      3'd4:    alu = a ^ b;
      3'd5:    alu = alt ? XLEN'($signed(a) >>> sh) : a >> sh;
      3'd6:    alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  // Entries are applied in ROB order from the head so later entries see earlier results.
  always_comb begin
    sh_n    = shadow_q;
    epc_n   = exp_pc_q;
    rdy_cnt = '0;
    idx     = '0;
    ent     = '0;
    rs1_v   = '0;
    rs2_v   = '0;
    res     = '0;
    wr      = 1'b0;
    for (int k = 0; k < ROB_SIZE; k++) begin
      idx = TAG_W'(flush.front_tag) + TAG_W'(k);
      ent = rdest[idx];
      if (ent.rdy) begin
        rdy_cnt = rdy_cnt + RC_W'(1);
        rs1_v   = sh_n[ent.pc_info.rs1];
        rs2_v   = sh_n[ent.pc_info.rs2];
        res     = '0;
        wr      = 1'b1;
        epc_n   = epc_n + XLEN'(4);
        case (ent.pc_info.opcode)
          OP_IMM:   res = alu(ent.pc_info.funct3, ent.pc_info.funct7[5], 1'b0, rs1_v, ent.pc_info.i_imm);
          OP_REG:   res = alu(ent.pc_info.funct3, ent.pc_info.funct7[5], 1'b1, rs1_v, rs2_v);
          OP_LUI:   res = ent.pc_info.u_imm;
          OP_AUIPC: res = ent.pc_info.pc + ent.pc_info.u_imm;
          OP_JAL: begin
            res   = ent.pc_info.pc + XLEN'(4);
            epc_n = ent.pc_info.pc + ent.pc_info.j_imm;
          end
          OP_JALR: begin
            res   = ent.pc_info.pc + XLEN'(4);
            epc_n = (rs1_v + ent.pc_info.i_imm) & {{(XLEN-1){1'b1}}, 1'b0};
          end
          OP_BR: begin
            wr    = 1'b0;
            epc_n = ent.pc_info.taken ? ent.pc_info.branch_pc : ent.pc_info.pc + XLEN'(4);
          end
          OP_LOAD:  res = ent.data;
          default:  wr = 1'b0;
        endcase
        if (wr) sh_n[ent.pc_info.rd] = res;
        sh_n[0] = '0;
      end
    end
  end

  // Descending scan so the lowest mismatching register index wins.
  always_comb begin
    any_mis = 1'b0;
    mis_idx = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (shadow_q[i] != cpu_registers[i].data) begin
        any_mis = 1'b1;
        mis_idx = 5'(i);
      end
    end
  end

  always_comb begin
    unused_f7 = 1'b0;
    for (int k = 0; k < ROB_SIZE; k++)
      unused_f7 = unused_f7 ^ (^{rdest[k].pc_info.funct7[6], rdest[k].pc_info.funct7[4:0]});
  end

`ifdef COMMIT_SCOREBOARD_PC_CHECK_EN
  logic [XLEN-1:0] ring_q [PC_HIST];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PC_HIST; i++) ring_q[i] <= '0;
    end else if (pc_load) begin
      ring_q[0] <= pc;
      for (int i = 1; i < PC_HIST; i++) ring_q[i] <= ring_q[i-1];
    end
  end

  always_comb begin
    pc_hit = 1'b0;
    for (int i = 0; i < PC_HIST; i++)
      if (ring_q[i] == exp_pc_q) pc_hit = 1'b1;
  end
`else
  logic unused_pc;
  assign unused_pc = (^{pc, pc_load}) ^ (PC_HIST == 0);
  assign pc_hit    = 1'b1;
`endif

  assign do_ingest  = commit && (state == S_RUN || state == S_CHECK);
  assign commit_sum = SUM_W'(num_commit) + SUM_W'(rdy_cnt);
  assign commit_sat = (commit_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : commit_sum[CNT_W-1:0];
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_RUN;
      exp_pc_q        <= RESET_PC;
      for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
      num_err         <= '0;
      num_commit      <= '0;
      mismatch        <= 1'b0;
      pc_mismatch     <= 1'b0;
      first_err_valid <= 1'b0;
      first_err_reg   <= '0;
      first_err_exp   <= '0;
      first_err_act   <= '0;
      done            <= 1'b0;
    end else begin
      mismatch    <= 1'b0;
      pc_mismatch <= 1'b0;
      if (do_ingest) begin
        shadow_q   <= sh_n;
        exp_pc_q   <= epc_n;
        num_commit <= commit_sat;
      end
      case (state)
        S_RUN:   if (commit) state <= S_CHECK;
        S_CHECK: begin
          if (any_mis) begin
            mismatch <= 1'b1;
            if (num_err != CNT_MAX) num_err <= num_err + CNT_W'(1);
            if (!first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_reg   <= mis_idx;
              first_err_exp   <= shadow_q[mis_idx];
              first_err_act   <= cpu_registers[mis_idx].data;
            end
          end
          pc_mismatch <= !pc_hit;
          state       <= commit ? S_CHECK : S_RUN;
        end
        S_HALTED: state <= S_HALTED;
        default:  state <= S_RUN;
      endcase
      if (halt) begin
        state <= S_HALTED;
        done  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_commit_scoreboard.sv
// Directed scoreboard bench for commit_scoreboard; a second instance with 2-bit counters covers saturation.
module tb_commit_scoreboard;
  import commit_scoreboard_pkg::*;

`ifdef COMMIT_SCOREBOARD_PC_CHECK_EN
  localparam logic PC_EN = 1'b1;
`else
  localparam logic PC_EN = 1'b0;
`endif

  logic        clk, rst, commit, halt, pc_load;
  logic [31:0] pc;
  sal2_t       rdest [8];
  flush_t      flush;
  reg_entry_t  cpu_registers [32];

  logic [15:0] num_err, num_commit;
  logic        mismatch, pc_mismatch, first_err_valid, done;
  logic [4:0]  first_err_reg;
  logic [31:0] first_err_exp, first_err_act;
  logic [1:0]  dbg_state;

  logic [1:0]  num_err2, num_commit2;
  logic        mismatch2, pc_mismatch2, first_err_valid2, done2;
  logic [4:0]  first_err_reg2;
  logic [31:0] first_err_exp2, first_err_act2;
  logic [1:0]  dbg_state2;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [1:0]  exp_q [$];
  logic [31:0] ring_m [8];
  logic        chk_prev = 1'b0;

  commit_scoreboard dut (
    .clk(clk), .rst(rst), .commit(commit), .rdest(rdest), .flush(flush),
    .cpu_registers(cpu_registers), .halt(halt), .pc(pc), .pc_load(pc_load),
    .num_err(num_err), .num_commit(num_commit), .mismatch(mismatch), .pc_mismatch(pc_mismatch),
    .first_err_valid(first_err_valid), .first_err_reg(first_err_reg),
    .first_err_exp(first_err_exp), .first_err_act(first_err_act), .done(done), .dbg_state(dbg_state)
  );

  commit_scoreboard #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .commit(commit), .rdest(rdest), .flush(flush),
    .cpu_registers(cpu_registers), .halt(halt), .pc(pc), .pc_load(pc_load),
    .num_err(num_err2), .num_commit(num_commit2), .mismatch(mismatch2), .pc_mismatch(pc_mismatch2),
    .first_err_valid(first_err_valid2), .first_err_reg(first_err_reg2),
    .first_err_exp(first_err_exp2), .first_err_act(first_err_act2), .done(done2), .dbg_state(dbg_state2)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic pcm(input logic [31:0] e);
    pcm = PC_EN;
    for (int i = 0; i < 8; i++) if (ring_m[i] == e) pcm = 1'b0;
  endfunction

  function automatic sal2_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] imm, input logic [31:0] epc);
    sal2_t e;
    e = '0;
    e.rdy            = 1'b1;
    e.pc_info.opcode = op;
    e.pc_info.funct3 = f3;
    e.pc_info.funct7 = f7;
    e.pc_info.rd     = rd;
    e.pc_info.rs1    = rs1;
    e.pc_info.rs2    = rs2;
    e.pc_info.i_imm  = imm;
    e.pc_info.u_imm  = imm;
    e.pc_info.j_imm  = imm;
    e.pc_info.pc     = epc;
    return e;
  endfunction

  // Driver tasks
  task automatic clear_rdest();
    for (int i = 0; i < 8; i++) rdest[i] = '0;
  endtask

  task automatic do_pc_load(input logic [31:0] v);
    pc      = v;
    pc_load = 1'b1;
    @(posedge clk); #1;
    pc_load = 1'b0;
    for (int i = 7; i > 0; i--) ring_m[i] = ring_m[i-1];
    ring_m[0] = v;
  endtask

  task automatic run_burst(input int ft, input logic [1:0] expv);
    flush.front_tag = 3'(ft);
    commit = 1'b1;
    exp_q.push_back(expv);
    @(posedge clk); #1;
    commit = 1'b0;
    clear_rdest();
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard: one result per cycle spent in CHECK
  always @(negedge clk) begin
    if (!rst) begin
      chk_prev = 1'b0;
    end else begin
      n_checks++;
      if (chk_prev) begin
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL check_result: got a check with no expected entry queued");
        end else begin
          logic [1:0] e;
          e = exp_q.pop_front();
          if ({mismatch, pc_mismatch} !== e) begin
            n_fail++;
            $display("FAIL check_result: got mismatch/pc_mismatch=%b expected %b", {mismatch, pc_mismatch}, e);
          end
        end
      end else if (mismatch !== 1'b0 || pc_mismatch !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_pulse: got mismatch/pc_mismatch=%b expected 00", {mismatch, pc_mismatch});
      end
      chk_prev = (dbg_state == 2'd1);
    end
  end

  initial begin
    rst = 1'b0; commit = 1'b0; halt = 1'b0; pc_load = 1'b0; pc = '0; flush = '0;
    clear_rdest();
    for (int i = 0; i < 32; i++) cpu_registers[i].data = '0;
    for (int i = 0; i < 8; i++) ring_m[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    chk("reset_num_err", 32'(num_err), 32'h0);
    chk("reset_num_commit", 32'(num_commit), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_first_valid", 32'(first_err_valid), 32'h0);
    chk("reset_state", 32'(dbg_state), 32'h0);
    chk("reset_exp_pc", dut.exp_pc_q, 32'h60);

    // Wrap-around: addi x1,x0,5 at slot 6, addi x2,x1,3 at slot 0
    rdest[6] = mk(OP_IMM, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 32'h60);
    rdest[0] = mk(OP_IMM, 3'd0, 7'h00, 5'd2, 5'd1, 5'd0, 32'd3, 32'h64);
    cpu_registers[1].data = 32'd5;
    cpu_registers[2].data = 32'd8;
    run_burst(6, {1'b0, pcm(32'h68)});
    chk("wrap_num_commit", 32'(num_commit), 32'd2);
    chk("wrap_exp_pc", dut.exp_pc_q, 32'h68);

    // slt x3,x4,x5 with x4=-1, x5=1 -> shadow x3=1, CPU reports 0
    rdest[0] = mk(OP_IMM, 3'd0, 7'h00, 5'd4, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h68);
    rdest[1] = mk(OP_IMM, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'd1, 32'h6C);
    rdest[2] = mk(OP_REG, 3'd2, 7'h00, 5'd3, 5'd4, 5'd5, 32'd0, 32'h70);
    cpu_registers[3].data = 32'd0;
    cpu_registers[4].data = 32'hFFFF_FFFF;
    cpu_registers[5].data = 32'd1;
    run_burst(0, {1'b1, pcm(32'h74)});
    chk("slt_num_err", 32'(num_err), 32'd1);
    chk("slt_first_valid", 32'(first_err_valid), 32'd1);
    chk("slt_first_reg", 32'(first_err_reg), 32'd3);
    chk("slt_first_exp", first_err_exp, 32'd1);
    chk("slt_first_act", first_err_act, 32'd0);
    chk("slt_num_commit", 32'(num_commit), 32'd5);

    // sub / sra / srl / sltu / lui / write to x0, wrapping from slot 3
    rdest[3] = mk(OP_REG, 3'd0, 7'h20, 5'd6, 5'd5, 5'd4, 32'd0, 32'h74);
    rdest[4] = mk(OP_REG, 3'd5, 7'h20, 5'd7, 5'd4, 5'd5, 32'd0, 32'h78);
    rdest[5] = mk(OP_REG, 3'd5, 7'h00, 5'd8, 5'd4, 5'd5, 32'd0, 32'h7C);
    rdest[6] = mk(OP_REG, 3'd3, 7'h00, 5'd9, 5'd4, 5'd5, 32'd0, 32'h80);
    rdest[7] = mk(OP_LUI, 3'd0, 7'h00, 5'd10, 5'd0, 5'd0, 32'h1234_5000, 32'h84);
    rdest[0] = mk(OP_IMM, 3'd0, 7'h00, 5'd0, 5'd5, 5'd0, 32'd7, 32'h88);
    cpu_registers[3].data  = 32'd1;
    cpu_registers[6].data  = 32'd2;
    cpu_registers[7].data  = 32'hFFFF_FFFF;
    cpu_registers[8].data  = 32'h7FFF_FFFF;
    cpu_registers[9].data  = 32'd0;
    cpu_registers[10].data = 32'h1234_5000;
    run_burst(3, {1'b0, pcm(32'h8C)});
    chk("alu_num_commit", 32'(num_commit), 32'd11);
    chk("alu_num_err", 32'(num_err), 32'd1);

    // Four back-to-back commits of addi x11,x11,1 while the CPU keeps x11=0
    flush.front_tag = 3'd0;
    rdest[0] = mk(OP_IMM, 3'd0, 7'h00, 5'd11, 5'd11, 5'd0, 32'd1, 32'h8C);
    commit = 1'b1;
    for (int j = 0; j < 4; j++) begin
      exp_q.push_back({1'b1, pcm(32'h8C + 32'(4 * (j + 1)))});
      @(posedge clk); #1;
    end
    commit = 1'b0;
    clear_rdest();
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_num_err", 32'(num_err), 32'd5);
    chk("b2b_num_commit", 32'(num_commit), 32'd15);
    chk("b2b_first_reg", 32'(first_err_reg), 32'd3);
    chk("sat_num_err", 32'(num_err2), 32'd3);
    chk("sat_num_commit", 32'(num_commit2), 32'd3);
    chk("sat_first_reg", 32'(first_err_reg2), 32'd3);
    chk("sat_first_exp", first_err_exp2, 32'd1);
    chk("sat_first_act", first_err_act2, 32'd0);
    cpu_registers[11].data = 32'd4;

    // jal at 0x60 with j_imm 0x20, history holds 0x80
    do_pc_load(32'h80);
    rdest[0] = mk(OP_JAL, 3'd0, 7'h00, 5'd12, 5'd0, 5'd0, 32'h20, 32'h60);
    cpu_registers[12].data = 32'h64;
    run_burst(0, 2'b00);
    chk("jal_exp_pc", dut.exp_pc_q, 32'h80);

    // Same jal after 0x80 has been pushed out of the history
    for (int i = 0; i < 8; i++) do_pc_load(32'h200 + 32'(4 * i));
    rdest[0] = mk(OP_JAL, 3'd0, 7'h00, 5'd12, 5'd0, 5'd0, 32'h20, 32'h60);
    run_burst(0, {1'b0, PC_EN});

    // auipc, jalr, branches, load, store, slli from slot 5
    do_pc_load(32'h4C);
    rdest[5] = mk(OP_AUIPC, 3'd0, 7'h00, 5'd14, 5'd0, 5'd0, 32'h1000, 32'h80);
    rdest[6] = mk(OP_JALR, 3'd0, 7'h00, 5'd13, 5'd5, 5'd0, 32'h11, 32'h84);
    rdest[7] = mk(OP_BR, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd0, 32'h12);
    rdest[7].pc_info.branch_pc = 32'h500;
    rdest[0] = mk(OP_BR, 3'd0, 7'h00, 5'd0, 5'd1, 5'd1, 32'd0, 32'h16);
    rdest[0].pc_info.taken     = 1'b1;
    rdest[0].pc_info.branch_pc = 32'h40;
    rdest[1] = mk(OP_LOAD, 3'd2, 7'h00, 5'd15, 5'd0, 5'd0, 32'd0, 32'h40);
    rdest[1].data = 32'hDEAD_BEEF;
    rdest[2] = mk(OP_STORE, 3'd2, 7'h00, 5'd20, 5'd1, 5'd2, 32'd0, 32'h44);
    rdest[3] = mk(OP_IMM, 3'd1, 7'h00, 5'd17, 5'd5, 5'd0, 32'd31, 32'h48);
    cpu_registers[13].data = 32'h88;
    cpu_registers[14].data = 32'h1080;
    cpu_registers[15].data = 32'hDEAD_BEEF;
    cpu_registers[17].data = 32'h8000_0000;
    run_burst(5, 2'b00);
    chk("mix_exp_pc", dut.exp_pc_q, 32'h4C);
    chk("mix_num_commit", 32'(num_commit), 32'd24);
    chk("mix_num_err", 32'(num_err), 32'd5);

    // Halt, then a mismatching commit must be ignored
    halt = 1'b1;
    @(posedge clk); #1;
    halt = 1'b0;
    chk("halt_done", 32'(done), 32'd1);
    chk("halt_state", 32'(dbg_state), 32'd2);
    rdest[0] = mk(OP_IMM, 3'd0, 7'h00, 5'd18, 5'd0, 5'd0, 32'd9, 32'h4C);
    flush.front_tag = 3'd0;
    commit = 1'b1;
    @(posedge clk); #1;
    commit = 1'b0;
    clear_rdest();
    repeat (3) @(posedge clk);
    #1;
    chk("halt_num_err", 32'(num_err), 32'd5);
    chk("halt_num_commit", 32'(num_commit), 32'd24);
    chk("halt_done_hold", 32'(done), 32'd1);
    chk("halt_sat_num_err", 32'(num_err2), 32'd3);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
